// File: rtl/rng_cal_multi_knob.sv
// rng_cal_multi_knob
// ------------------
// Bias calibration for an inverter-pair TRNG with several trim pairs.
// Each iteration lets the analog macro settle after a code change, counts
// the ones in a 2^WIN_LOG2-sample window and then nudges the active pair's
// conf1/conf0 codes toward balance. When a pair runs out of range in the
// required direction, the next pair is used. Calibration ends in DONE
// (balanced, or the direction reversed on the same pair) or in FAIL (every
// pair exhausted).
//
// Ports
//   clk               rising-edge clock
//   resetb            asynchronous active-low reset
//   start             one-cycle request; honoured only in IDLE/DONE/FAIL
//   bit_from_inv_pair raw RNG bit, already synchronised to clk
//   conf1_bus         conf1 codes, pair k at [k*CONF_W +: CONF_W]
//   conf0_bus         conf0 codes, same packing
//   knob_idx          active pair index
//   ones_last         ones count of the most recent completed window
//   busy              high in every state except IDLE/DONE/FAIL
//   done              level, calibration converged
//   fail              level, all pairs exhausted
//   pres_state_out    current FSM state encoding
module rng_cal_multi_knob #(
  parameter int CONF_W     = 4,
  parameter int N_KNOBS    = 3,
  parameter int WIN_LOG2   = 6,
  parameter int TOL        = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       start,
  input  logic                       bit_from_inv_pair,
  output logic [N_KNOBS*CONF_W-1:0]  conf1_bus,
  output logic [N_KNOBS*CONF_W-1:0]  conf0_bus,
  output logic [2:0]                 knob_idx,
  output logic [WIN_LOG2:0]          ones_last,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic [3:0]                 pres_state_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    SAMPLE    = 3'd2,
    EVAL      = 3'd3,
    ADJUST    = 3'd4,
    NEXT_KNOB = 3'd5,
    DONE      = 3'd6,
    FAIL      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_HI   = 2'd1,
    DIR_LO   = 2'd2
  } dir_t;

  localparam int CNT_W = WIN_LOG2 + 1;
  localparam int HALF  = 2 ** (WIN_LOG2 - 1);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CONF_W-1:0] MID   = CONF_W'(2 ** (CONF_W - 1));
  localparam logic [CONF_W-1:0] MAXC  = {CONF_W{1'b1}};
  localparam logic [CNT_W-1:0]  HI_TH = CNT_W'(HALF + TOL);
  localparam logic [CNT_W-1:0]  LO_TH = CNT_W'(HALF - TOL);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [2:0]        LAST_KNOB   = 3'(N_KNOBS - 1);

  state_t              state, state_nxt;
  dir_t                last_dir;
  logic [SET_W-1:0]    settle_cnt;
  logic [WIN_LOG2-1:0] samp_cnt;
  logic [CNT_W-1:0]    ones_cnt;

  logic [CONF_W-1:0]   cur1, cur0;
  logic                cnt_hi, cnt_lo, adj_hi;
  logic                hi_exh, lo_exh;

  // Codes of the active trim pair, picked out of the packed buses.
  always_comb begin
    cur1 = '0;
    cur0 = '0;
    for (int k = 0; k < N_KNOBS; k++) begin
      if (knob_idx == 3'(k)) begin
        cur1 = conf1_bus[k*CONF_W +: CONF_W];
        cur0 = conf0_bus[k*CONF_W +: CONF_W];
      end
    end
  end

  // Bias decisions. EVAL judges the fresh count; ADJUST re-derives the same
  // direction from ones_last, which EVAL has just loaded. Thresholds are
  // unsigned and HALF-TOL is always >= 1, so nothing underflows.
  always_comb begin
    cnt_hi = ones_cnt > HI_TH;
    cnt_lo = ones_cnt < LO_TH;
    adj_hi = ones_last > HI_TH;
    hi_exh = (cur1 == '0) && (cur0 == MAXC);
    lo_exh = (cur0 == '0) && (cur1 == MAXC);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, FAIL: if (start) state_nxt = SETTLE;
      SETTLE:           if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:           if (&samp_cnt) state_nxt = EVAL;
      EVAL: begin
        if (!cnt_hi && !cnt_lo)
          state_nxt = DONE;
        else if ((cnt_hi && last_dir == DIR_LO) || (cnt_lo && last_dir == DIR_HI))
          state_nxt = DONE;
        else if ((cnt_hi && hi_exh) || (cnt_lo && lo_exh))
          state_nxt = NEXT_KNOB;
        else
          state_nxt = ADJUST;
      end
      ADJUST:           state_nxt = SETTLE;
      NEXT_KNOB:        state_nxt = (knob_idx == LAST_KNOB) ? FAIL : SETTLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // Datapath: counters, trim codes, pair index and direction memory.
  // settle_cnt is left at zero whenever SETTLE is exited, so ADJUST and
  // NEXT_KNOB can enter SETTLE without touching it.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      conf1_bus  <= {N_KNOBS{MID}};
      conf0_bus  <= {N_KNOBS{MID}};
      knob_idx   <= '0;
      ones_last  <= '0;
      last_dir   <= DIR_NONE;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      ones_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            conf1_bus  <= {N_KNOBS{MID}};
            conf0_bus  <= {N_KNOBS{MID}};
            knob_idx   <= '0;
            last_dir   <= DIR_NONE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            samp_cnt   <= '0;
            ones_cnt   <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          ones_cnt <= ones_cnt + {{WIN_LOG2{1'b0}}, bit_from_inv_pair};
          samp_cnt <= samp_cnt + 1'b1;
        end
        EVAL: ones_last <= ones_cnt;
        ADJUST: begin
          // Exactly one code of the active pair moves by one step.
          for (int k = 0; k < N_KNOBS; k++) begin
            if (knob_idx == 3'(k)) begin
              if (adj_hi) begin
                if (cur1 != '0) conf1_bus[k*CONF_W +: CONF_W] <= cur1 - 1'b1;
                else            conf0_bus[k*CONF_W +: CONF_W] <= cur0 + 1'b1;
              end else begin
                if (cur0 != '0) conf0_bus[k*CONF_W +: CONF_W] <= cur0 - 1'b1;
                else            conf1_bus[k*CONF_W +: CONF_W] <= cur1 + 1'b1;
              end
            end
          end
          last_dir <= adj_hi ? DIR_HI : DIR_LO;
        end
        NEXT_KNOB: begin
          if (knob_idx != LAST_KNOB) begin
            knob_idx <= knob_idx + 3'd1;
            last_dir <= DIR_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy           = !((state == IDLE) || (state == DONE) || (state == FAIL));
    done           = (state == DONE);
    fail           = (state == FAIL);
    pres_state_out = {1'b0, state};
  end

endmodule

// File: tb/tb_rng_cal_multi_knob.sv
// tb_rng_cal_multi_knob
// Directed bench for rng_cal_multi_knob. Instance dut_a uses the default
// parameters; dut_b uses a single trim pair. The raw bit is produced by a
// small source model selected with mode_a / mode_b.
module tb_rng_cal_multi_knob;

  logic        clk = 1'b0;
  logic        resetb;
  logic        start_a, start_b;
  logic        bit_a, bit_b;

  logic [11:0] conf1_a, conf0_a;
  logic [2:0]  knob_a;
  logic [6:0]  ones_a;
  logic        busy_a, done_a, fail_a;
  logic [3:0]  state_a;

  logic [3:0]  conf1_b, conf0_b;
  logic [2:0]  knob_b;
  logic [6:0]  ones_b;
  logic        busy_b, done_b, fail_b;
  logic [3:0]  state_b;

  int vectors     = 0;
  int miscompares = 0;
  int mode_a      = 2;
  int mode_b      = 0;
  int phase       = 0;

  always #5 clk = ~clk;

  rng_cal_multi_knob dut_a (
    .clk(clk), .resetb(resetb), .start(start_a), .bit_from_inv_pair(bit_a),
    .conf1_bus(conf1_a), .conf0_bus(conf0_a), .knob_idx(knob_a),
    .ones_last(ones_a), .busy(busy_a), .done(done_a), .fail(fail_a),
    .pres_state_out(state_a)
  );

  rng_cal_multi_knob #(.N_KNOBS(1)) dut_b (
    .clk(clk), .resetb(resetb), .start(start_b), .bit_from_inv_pair(bit_b),
    .conf1_bus(conf1_b), .conf0_bus(conf0_b), .knob_idx(knob_b),
    .ones_last(ones_b), .busy(busy_b), .done(done_b), .fail(fail_b),
    .pres_state_out(state_b)
  );

  // Bit source: 0 = constant 0, 1 = constant 1, 2 = alternating (32/64),
  // 3 = biased model: 3-of-4 ones (48/64) while pair 0 conf1 > 5, else
  // 1-of-4 ones (16/64). Any 64 consecutive samples give those exact counts.
  initial begin
    bit_a = 1'b0;
    bit_b = 1'b0;
    forever begin
      @(negedge clk);
      phase++;
      case (mode_a)
        0: bit_a = 1'b0;
        1: bit_a = 1'b1;
        2: bit_a = phase[0];
        default: bit_a = (conf1_a[3:0] > 4'd5) ? ((phase % 4) != 0) : ((phase % 4) == 0);
      endcase
      bit_b = (mode_b == 1);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulses start on the selected instance; returns after the sampling edge.
  task automatic applyStimulus(input int which);
    @(negedge clk);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    resetb  = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_conf1", 32'(conf1_a), 32'h888);
    checkOutput("rst_conf0", 32'(conf0_a), 32'h888);
    checkOutput("rst_flags", {busy_a, done_a, fail_a}, 3'b000);
    checkOutput("rst_state", 32'(state_a), 0);
    resetb = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_state", 32'(state_a), 0);
    checkOutput("idle_busy", 32'(busy_a), 0);

    // Balanced input: done exactly 70 edges after the start edge.
    mode_a = 2;
    applyStimulus(0);
    checkOutput("bal_busy", 32'(busy_a), 1);
    repeat (68) @(negedge clk);
    checkOutput("bal_done_69", 32'(done_a), 0);
    @(negedge clk);
    checkOutput("bal_done_70", 32'(done_a), 1);
    checkOutput("bal_ones", 32'(ones_a), 32);
    checkOutput("bal_conf1", 32'(conf1_a), 32'h888);
    checkOutput("bal_conf0", 32'(conf0_a), 32'h888);
    checkOutput("bal_idx", 32'(knob_a), 0);
    checkOutput("bal_state", 32'(state_a), 6);

    // Asynchronous reset in the middle of SAMPLE.
    applyStimulus(0);
    repeat (30) @(negedge clk);
    checkOutput("mid_state", 32'(state_a), 2);
    #2 resetb = 1'b0;
    #1;
    checkOutput("arst_state", 32'(state_a), 0);
    checkOutput("arst_ones", 32'(ones_a), 0);
    checkOutput("arst_flags", {busy_a, done_a, fail_a}, 3'b000);
    checkOutput("arst_conf1", 32'(conf1_a), 32'h888);
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);

    // Extra start during SAMPLE must not disturb the run.
    applyStimulus(0);
    repeat (20) @(negedge clk);
    applyStimulus(0);
    checkOutput("ign_state", 32'(state_a), 2);
    repeat (46) @(negedge clk);
    checkOutput("ign_done_69", 32'(done_a), 0);
    @(negedge clk);
    checkOutput("ign_done_70", 32'(done_a), 1);
    checkOutput("ign_ones", 32'(ones_a), 32);
    checkOutput("ign_conf1", 32'(conf1_a), 32'h888);

    // Constant 1: every trim pair exhausted high, then FAIL.
    mode_a = 1;
    applyStimulus(0);
    for (int i = 0; i < 6000 && !fail_a; i++) @(negedge clk);
    checkOutput("c1_fail", 32'(fail_a), 1);
    checkOutput("c1_conf1", 32'(conf1_a), 32'h000);
    checkOutput("c1_conf0", 32'(conf0_a), 32'hFFF);
    checkOutput("c1_ones", 32'(ones_a), 64);
    checkOutput("c1_idx", 32'(knob_a), 2);
    checkOutput("c1_done", 32'(done_a), 0);

    // Biased model: conf1 8->7->6->5, then reversal stops on DONE.
    mode_a = 3;
    applyStimulus(0);
    checkOutput("mdl_reload", 32'(conf1_a), 32'h888);
    checkOutput("mdl_fail_clr", 32'(fail_a), 0);
    for (int i = 0; i < 1000 && !done_a; i++) @(negedge clk);
    checkOutput("mdl_done", 32'(done_a), 1);
    checkOutput("mdl_conf1", 32'(conf1_a), 32'h885);
    checkOutput("mdl_conf0", 32'(conf0_a), 32'h888);
    checkOutput("mdl_idx", 32'(knob_a), 0);
    checkOutput("mdl_ones", 32'(ones_a), 16);

    // Single trim pair, constant 0: exhausted low, FAIL, then restart.
    mode_b = 0;
    applyStimulus(1);
    for (int i = 0; i < 2000 && !fail_b; i++) @(negedge clk);
    checkOutput("p1_fail", 32'(fail_b), 1);
    checkOutput("p1_conf0", 32'(conf0_b), 32'h0);
    checkOutput("p1_conf1", 32'(conf1_b), 32'hF);
    checkOutput("p1_ones", 32'(ones_b), 0);
    applyStimulus(1);
    checkOutput("p1_rs_conf1", 32'(conf1_b), 32'h8);
    checkOutput("p1_rs_conf0", 32'(conf0_b), 32'h8);
    checkOutput("p1_rs_fail", 32'(fail_b), 0);
    checkOutput("p1_rs_state", 32'(state_b), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
